uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one synchronous valid/ready link, the input side of the sync-to-async req/ack converter feeding the UART transmit path, among NUM_REQ byte producers. It captures one beat from the winning requester and holds it stable on the link until the transfer completes. It enforces a one-cycle valid gap between beats and bounded burst locking, and aborts beats the downstream never accepts.

---
 rtl/uart_tx_arbiter_pkg.sv | 9 +
 rtl/rr_priority_picker.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 78 +++++++
 tb/tb_uart_tx_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: arbiter state encoding and ID width helper, shared with the RX-side scheduler
package uart_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request scanning upward from ptr+1, wrapping; ptr itself is checked last
module rr_priority_picker import uart_arb_pkg::*; #(
  parameter int N = 4,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && |(req & (N'(1) << ((int'(ptr) + k) % N)))) begin
        found = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
    onehot = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one valid/ready link with burst locking, beat gap and timeout abort
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT = 1024,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
  output logic                          sync_valid,
  input  logic                          sync_ready,
  output logic [DATA_WIDTH-1:0]         sync_d,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err,
  output logic                          busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT);
  logic [1:0] state;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0] pick_idx, win;
  logic pick_found, lock, win_ok;
  rr_priority_picker #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(grant_id),
    .onehot(pick_onehot),
    .idx(pick_idx),
    .found(pick_found)
  );
  assign lock = state == GAP && burst_cnt < BW'(MAX_BURST) && req_valid[grant_id];
  assign win = lock ? grant_id : pick_idx;
  assign win_ok = state != SEND && (lock || pick_found);
  assign req_ready = win_ok ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sync_valid <= 1'b0;
      sync_d <= '0;
      grant_id <= ID_W'(NUM_REQ - 1);
      timeout_err <= 1'b0;
      busy <= 1'b0;
      burst_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (win_ok) begin
        state <= SEND;
        sync_valid <= 1'b1;
        busy <= 1'b1;
        sync_d <= DATA_WIDTH'(req_d >> (int'(win) * DATA_WIDTH));
        grant_id <= win;
        burst_cnt <= lock ? burst_cnt + 1'b1 : BW'(1);
        wait_cnt <= '0;
      end else if (state == GAP) begin
        state <= IDLE;
      end else if (state == SEND) begin
        if (sync_ready || wait_cnt == WW'(TIMEOUT - 1)) begin
          state <= GAP;
          sync_valid <= 1'b0;
          busy <= 1'b0;
          // an abandoned beat saturates the burst so the owner loses the lock
          if (!sync_ready) begin
            timeout_err <= 1'b1;
            burst_cnt <= BW'(MAX_BURST);
          end
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of capture, burst locking, rotation, timeout and async reset
module tb_uart_tx_arbiter;
  logic clock = 1'b0, reset = 1'b1, sync_ready = 1'b0;
  logic [3:0] req_valid = '0, req_valid_b = '0;
  logic [31:0] req_d = '0;
  logic [3:0] req_ready_a, req_ready_b;
  logic sync_valid_a, sync_valid_b, timeout_err_a, timeout_err_b, busy_a, busy_b;
  logic [7:0] sync_d_a, sync_d_b;
  logic [1:0] grant_id_a, grant_id_b;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  uart_tx_arbiter #(.MAX_BURST(4), .TIMEOUT(16)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_d(req_d), .sync_valid(sync_valid_a), .sync_ready(sync_ready), .sync_d(sync_d_a),
    .grant_id(grant_id_a), .timeout_err(timeout_err_a), .busy(busy_a)
  );
  uart_tx_arbiter #(.MAX_BURST(1), .TIMEOUT(16)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_d(req_d), .sync_valid(sync_valid_b), .sync_ready(sync_ready), .sync_d(sync_d_b),
    .grant_id(grant_id_b), .timeout_err(timeout_err_b), .busy(busy_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", 32'(sync_valid_a), 0);
    chk("rst_d", 32'(sync_d_a), 0);
    chk("rst_grant", 32'(grant_id_a), 3);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_terr", 32'(timeout_err_a), 0);
    chk("rst_ready", 32'(req_ready_a), 0);
    @(negedge clock);
    req_valid = 4'b0100;
    req_d = 32'h00A5_0000;
    reset = 1'b1;
    #1 chk("t1_req_ready", 32'(req_ready_a), 32'b0100);
    @(negedge clock);
    chk("t1_valid", 32'(sync_valid_a), 1);
    chk("t1_busy", 32'(busy_a), 1);
    chk("t1_ready_send", 32'(req_ready_a), 0);
    req_valid = '0;
    req_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      chk("t1_hold_valid", 32'(sync_valid_a), 1);
      chk("t1_hold_d", 32'(sync_d_a), 32'hA5);
      chk("t1_hold_grant", 32'(grant_id_a), 2);
    end
    sync_ready = 1'b1;
    @(negedge clock);
    chk("t1_gap_valid", 32'(sync_valid_a), 0);
    chk("t1_gap_busy", 32'(busy_a), 0);
    sync_ready = 1'b0;
    @(negedge clock);
    chk("t1_idle_valid", 32'(sync_valid_a), 0);
    reset = 1'b0;
    @(negedge clock);
    req_valid = 4'hF;
    req_d = 32'h1312_1110;
    sync_ready = 1'b1;
    reset = 1'b1;
    #1 chk("t2_first_ready", 32'(req_ready_a), 32'b0001);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      chk("t2_valid", 32'(sync_valid_a), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("t2_grant", 32'(grant_id_a), 32'(((k - 1) / 8) % 4));
        chk("t2_data", 32'(sync_d_a), 32'(8'h10 + ((k - 1) / 8) % 4));
      end
    end
    req_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    req_valid_b = 4'b1010;
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk("t3_valid", 32'(sync_valid_b), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("t3_grant", 32'(grant_id_b), ((k - 1) / 2) % 2 == 1 ? 3 : 1);
        chk("t3_data", 32'(sync_d_b), ((k - 1) / 2) % 2 == 1 ? 32'h13 : 32'h11);
      end
    end
    req_valid_b = '0;
    sync_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    req_valid = 4'b0011;
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk("t4_wait_valid", 32'(sync_valid_a), 1);
      chk("t4_wait_terr", 32'(timeout_err_a), 0);
    end
    chk("t4_wait_grant", 32'(grant_id_a), 0);
    @(negedge clock);
    chk("t4_terr", 32'(timeout_err_a), 1);
    chk("t4_drop_valid", 32'(sync_valid_a), 0);
    @(negedge clock);
    chk("t4_terr_pulse", 32'(timeout_err_a), 0);
    chk("t4_rot_valid", 32'(sync_valid_a), 1);
    chk("t4_rot_grant", 32'(grant_id_a), 1);
    repeat (15) @(negedge clock);
    chk("t5_last_valid", 32'(sync_valid_a), 1);
    sync_ready = 1'b1;
    @(negedge clock);
    chk("t5_terr", 32'(timeout_err_a), 0);
    chk("t5_xfer_valid", 32'(sync_valid_a), 0);
    sync_ready = 1'b0;
    @(negedge clock);
    chk("t5_lock_valid", 32'(sync_valid_a), 1);
    chk("t5_lock_grant", 32'(grant_id_a), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(sync_valid_a), 0);
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_terr", 32'(timeout_err_a), 0);
    chk("t6_grant", 32'(grant_id_a), 3);
    @(negedge clock);
    req_valid = 4'hF;
    reset = 1'b1;
    #1 chk("t6_prio_ready", 32'(req_ready_a), 32'b0001);
    @(negedge clock);
    chk("t6_prio_grant", 32'(grant_id_a), 0);
    chk("t6_prio_data", 32'(sync_d_a), 32'h10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
